// File: rtl/comma_word_aligner_if.sv
// Serial-in / aligned-symbol-out bundle for the comma word aligner.
// The master drives the serial line and the realign request; the slave is the aligner.
interface comma_word_aligner_if;
  logic       i_Ser_Data;
  logic       i_Bit_Valid;
  logic       i_Realign;
  logic [9:0] o_10B;
  logic       o_Sym_Valid;
  logic       o_Is_Comma;
  logic       o_Locked;
  logic [7:0] o_Loss_Cnt;

  modport master (
    output i_Ser_Data, i_Bit_Valid, i_Realign,
    input  o_10B, o_Sym_Valid, o_Is_Comma, o_Locked, o_Loss_Cnt
  );

  modport slave (
    input  i_Ser_Data, i_Bit_Valid, i_Realign,
    output o_10B, o_Sym_Valid, o_Is_Comma, o_Locked, o_Loss_Cnt
  );
endinterface

// File: rtl/comma_word_aligner.sv
// K28.5 comma hunter and 10-bit symbol aligner for an 8b/10b serial stream.
// Bit-clock domain; one serial bit is consumed per qualified clock.
module comma_word_aligner #(
  parameter int unsigned LOCK_COMMAS = 3,
  parameter int unsigned LOSS_ERRS   = 4
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  comma_word_aligner_if.slave  bus
);
  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_SYNC   = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam logic [9:0] K28_5_NEG  = 10'b0011111010;
  localparam logic [9:0] K28_5_POS  = 10'b1100000101;
  localparam logic [3:0] FILL_FULL  = 4'd9;
  localparam logic [3:0] PHASE_LAST = 4'd9;
  localparam logic [3:0] LOCK_N     = 4'(LOCK_COMMAS);
  localparam logic [3:0] LOSS_N     = 4'(LOSS_ERRS);

  logic [1:0] state;
  logic [9:0] sr;
  logic [3:0] fill;
  logic [3:0] cnt;
  logic [3:0] ccnt;
  logic [3:0] ecnt;
  logic [9:0] sym_q;
  logic       sym_valid_q;
  logic       is_comma_q;
  logic       locked_q;
  logic [7:0] loss_q;

  logic [9:0] nxt;
  logic       hit;
  logic       bnd;
  logic [3:0] cnt_inc;
  logic [3:0] ccnt_inc;
  logic [3:0] ecnt_inc;

  // The fill guard keeps the zeroed shift register from matching before 10 real bits arrive.
  assign nxt      = {sr[8:0], bus.i_Ser_Data};
  assign hit      = bus.i_Bit_Valid & (fill == FILL_FULL) &
                    ((nxt == K28_5_NEG) | (nxt == K28_5_POS));
  assign bnd      = bus.i_Bit_Valid & (cnt == PHASE_LAST);
  assign cnt_inc  = (cnt == PHASE_LAST) ? 4'd0 : cnt + 4'd1;
  assign ccnt_inc = ccnt + 4'd1;
  assign ecnt_inc = ecnt + 4'd1;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state       <= ST_HUNT;
      sr          <= '0;
      fill        <= '0;
      cnt         <= '0;
      ccnt        <= '0;
      ecnt        <= '0;
      sym_q       <= '0;
      sym_valid_q <= 1'b0;
      is_comma_q  <= 1'b0;
      locked_q    <= 1'b0;
      loss_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so later statements override earlier defaults
      // while every condition still sees the pre-edge register values.
      sym_valid_q <= 1'b0;
      if (bus.i_Bit_Valid) sr <= nxt;

      if (bus.i_Realign) begin
        if (state == ST_LOCKED && loss_q != 8'hFF) loss_q <= loss_q + 8'd1;
        state    <= ST_HUNT;
        locked_q <= 1'b0;
        fill     <= '0;
        cnt      <= '0;
        ccnt     <= '0;
        ecnt     <= '0;
      end else if (bus.i_Bit_Valid) begin
        if (fill != FILL_FULL) fill <= fill + 4'd1;
        case (state)
          ST_HUNT: begin
            if (hit) begin
              cnt         <= '0;
              sym_q       <= nxt;
              sym_valid_q <= 1'b1;
              is_comma_q  <= 1'b1;
              ccnt        <= 4'd1;
              if (LOCK_N == 4'd1) begin
                state    <= ST_LOCKED;
                locked_q <= 1'b1;
                ecnt     <= '0;
              end else begin
                state <= ST_SYNC;
              end
            end
          end
          ST_SYNC: begin
            cnt <= cnt_inc;
            if (bnd) begin
              sym_q       <= nxt;
              sym_valid_q <= 1'b1;
              is_comma_q  <= hit;
              if (hit) begin
                ccnt <= ccnt_inc;
                if (ccnt_inc == LOCK_N) begin
                  state    <= ST_LOCKED;
                  locked_q <= 1'b1;
                  ecnt     <= '0;
                end
              end
            end else if (hit) begin
              // Comma off the current phase: trust it and restart the lock count.
              cnt         <= '0;
              sym_q       <= nxt;
              sym_valid_q <= 1'b1;
              is_comma_q  <= 1'b1;
              ccnt        <= 4'd1;
            end
          end
          ST_LOCKED: begin
            cnt <= cnt_inc;
            if (bnd) begin
              sym_q       <= nxt;
              sym_valid_q <= 1'b1;
              is_comma_q  <= hit;
              if (hit) ecnt <= '0;
            end else if (hit) begin
              ecnt <= ecnt_inc;
              if (ecnt_inc == LOSS_N) begin
                state    <= ST_HUNT;
                locked_q <= 1'b0;
                fill     <= '0;
                if (loss_q != 8'hFF) loss_q <= loss_q + 8'd1;
              end
            end
          end
          default: state <= ST_HUNT;
        endcase
      end
    end
  end

  assign bus.o_10B       = sym_q;
  assign bus.o_Sym_Valid = sym_valid_q;
  assign bus.o_Is_Comma  = is_comma_q;
  assign bus.o_Locked    = locked_q;
  assign bus.o_Loss_Cnt  = loss_q;
endmodule

// File: tb/tb_comma_word_aligner.sv
// Self-checking bench for comma_word_aligner: directed scenarios plus random streams,
// all compared against a bit-index based behavioural model of the alignment rules.
module tb_comma_word_aligner;
  localparam int         LOCK_COMMAS = 3;
  localparam int         LOSS_ERRS   = 4;
  localparam logic [9:0] K_NEG       = 10'b0011111010;
  localparam logic [9:0] K_POS       = 10'b1100000101;
  localparam logic [9:0] D21_5       = 10'b1010101010;

  logic i_Clk = 1'b0;
  logic i_Rst = 1'b0;

  comma_word_aligner_if bus ();

  comma_word_aligner #(
    .LOCK_COMMAS (LOCK_COMMAS),
    .LOSS_ERRS   (LOSS_ERRS)
  ) dut (
    .i_Clk (i_Clk),
    .i_Rst (i_Rst),
    .bus   (bus)
  );

  always #5 i_Clk = ~i_Clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: alignment tracked as bit indices (anchor comma, HUNT entry) instead of counters.
  typedef enum {M_HUNT, M_SYNC, M_LOCKED} mstate_e;
  mstate_e    m_st;
  bit         hist[$];
  int         m_n, m_entry, m_anchor, m_commas, m_errs;
  logic       m_sv, m_ic, m_locked;
  logic [7:0] m_loss;
  logic [9:0] m_sym;

  // Vector layout: {sym_valid[20], is_comma[19], locked[18], loss[17:10], sym[9:0]}
  logic [20:0] obs_q[$];
  logic [20:0] exp_q[$];
  logic [20:0] stb_q[$];
  int          stb_cyc_q[$];

  function automatic logic [20:0] obs_vec();
    return {bus.o_Sym_Valid, bus.o_Is_Comma, bus.o_Locked, bus.o_Loss_Cnt, bus.o_10B};
  endfunction

  task automatic model_reset();
    m_st = M_HUNT; hist.delete();
    m_n = 0; m_entry = 0; m_anchor = 0; m_commas = 0; m_errs = 0;
    m_sv = 0; m_ic = 0; m_locked = 0; m_loss = '0; m_sym = '0;
  endtask

  task automatic model_emit(input logic [9:0] w, input logic ic);
    m_sym = w; m_sv = 1'b1; m_ic = ic;
  endtask

  task automatic model_step(input bit b, input bit v, input bit r);
    logic [9:0] win;
    int  idx;
    bit  hit, bnd;
    m_sv = 1'b0;
    idx  = -1;
    if (v) begin
      hist.push_back(b);
      if (hist.size() > 10) void'(hist.pop_front());
      idx = m_n;
      m_n++;
    end
    if (r) begin
      if (m_st == M_LOCKED && m_loss != 8'd255) m_loss++;
      m_st = M_HUNT; m_entry = m_n; m_commas = 0; m_errs = 0; m_locked = 1'b0;
      return;
    end
    if (!v) return;
    win = '0;
    foreach (hist[i]) win = {win[8:0], hist[i]};
    hit = ((win == K_NEG) || (win == K_POS)) && (idx - m_entry >= 9);
    bnd = (m_st != M_HUNT) && (idx > m_anchor) && ((idx - m_anchor) % 10 == 0);
    case (m_st)
      M_HUNT: if (hit) begin
        m_anchor = idx; model_emit(win, 1'b1); m_commas = 1;
        if (LOCK_COMMAS == 1) begin m_st = M_LOCKED; m_locked = 1'b1; m_errs = 0; end
        else m_st = M_SYNC;
      end
      M_SYNC: if (bnd) begin
        model_emit(win, hit);
        if (hit) begin
          m_commas++;
          if (m_commas == LOCK_COMMAS) begin m_st = M_LOCKED; m_locked = 1'b1; m_errs = 0; end
        end
      end else if (hit) begin
        m_anchor = idx; model_emit(win, 1'b1); m_commas = 1;
      end
      M_LOCKED: if (bnd) begin
        model_emit(win, hit);
        if (hit) m_errs = 0;
      end else if (hit) begin
        m_errs++;
        if (m_errs == LOSS_ERRS) begin
          m_st = M_HUNT; m_entry = m_n; m_locked = 1'b0;
          if (m_loss != 8'd255) m_loss++;
        end
      end
      default: ;
    endcase
  endtask

  // One clock: drive inputs, advance the model, sample the DUT 1 ns after the edge.
  task automatic step(input bit b, input bit v, input bit r);
    bus.i_Ser_Data  = b;
    bus.i_Bit_Valid = v;
    bus.i_Realign   = r;
    if (i_Rst) model_reset();
    else       model_step(b, v, r);
    @(posedge i_Clk);
    #1;
    cyc++;
    obs_q.push_back(obs_vec());
    exp_q.push_back({m_sv, m_ic, m_locked, m_loss, m_sym});
    if (bus.o_Sym_Valid === 1'b1) begin
      stb_q.push_back(obs_vec());
      stb_cyc_q.push_back(cyc);
    end
  endtask

  task automatic clear_logs();
    obs_q.delete(); exp_q.delete(); stb_q.delete(); stb_cyc_q.delete();
  endtask

  task automatic send_n(input logic [15:0] bits, input int n, input bit gapped);
    for (int i = n - 1; i >= 0; i--) begin
      step(bits[i], 1'b1, 1'b0);
      if (gapped) step(1'($urandom), 1'b0, 1'b0);
    end
  endtask

  task automatic do_reset();
    i_Rst = 1'b1;
    for (int i = 0; i < 3; i++) step(1'($urandom), 1'($urandom), 1'b0);
    i_Rst = 1'b0;
  endtask

  task automatic lock_up();
    send_n(16'b0101, 4, 1'b0);
    send_n(16'(K_NEG), 10, 1'b0);
    send_n(16'(K_POS), 10, 1'b0);
    send_n(16'(K_NEG), 10, 1'b0);
  endtask

  task automatic test_reset();
    clear_logs();
    do_reset();
    foreach (obs_q[i]) begin
      n_checks++;
      if (obs_q[i] !== 21'd0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: got %h expected 0", i, obs_q[i]);
      end
    end
    clear_logs();
    send_n(16'b11111010, 8, 1'b0);
    foreach (obs_q[i]) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i] || obs_q[i][20] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_fill_guard bit %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_acquire(input bit gapped);
    logic [9:0] exp_sym[4];
    logic       exp_ic[4];
    exp_sym = '{K_NEG, D21_5, K_POS, K_NEG};
    exp_ic  = '{1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();
    clear_logs();
    lock_up_with_data(gapped);
    foreach (obs_q[i]) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL acquire_model g%0d cycle %0d: got %h expected %h", gapped, i, obs_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (stb_q.size() !== 4) begin
      n_fail++;
      $display("FAIL acquire_strobe_count g%0d: got %0d expected 4", gapped, stb_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (stb_q[i][9:0] !== exp_sym[i] || stb_q[i][19] !== exp_ic[i]) begin
          n_fail++;
          $display("FAIL acquire_symbol g%0d #%0d: got %b/%b expected %b/%b",
                   gapped, i, stb_q[i][9:0], stb_q[i][19], exp_sym[i], exp_ic[i]);
        end
        if (i > 0) begin
          n_checks++;
          if (stb_cyc_q[i] - stb_cyc_q[i-1] !== (gapped ? 20 : 10)) begin
            n_fail++;
            $display("FAIL acquire_spacing g%0d #%0d: got %0d expected %0d",
                     gapped, i, stb_cyc_q[i] - stb_cyc_q[i-1], gapped ? 20 : 10);
          end
        end
      end
      n_checks++;
      if (stb_q[2][18] !== 1'b0 || stb_q[3][18] !== 1'b1) begin
        n_fail++;
        $display("FAIL acquire_lock_edge g%0d: got %b%b expected 01", gapped, stb_q[2][18], stb_q[3][18]);
      end
    end
  endtask

  task automatic lock_up_with_data(input bit gapped);
    send_n(16'b0101, 4, gapped);
    send_n(16'(K_NEG), 10, gapped);
    send_n(16'(D21_5), 10, gapped);
    send_n(16'(K_POS), 10, gapped);
    send_n(16'(K_NEG), 10, gapped);
  endtask

  task automatic test_slip();
    logic [2:0] lk;
    do_reset();
    clear_logs();
    send_n(16'b0101, 4, 1'b0);
    send_n(16'(K_NEG), 10, 1'b0);
    send_n(16'b0, 1, 1'b0);
    send_n(16'(K_POS), 10, 1'b0);
    lk[0] = bus.o_Locked;
    n_checks++;
    if (bus.o_Sym_Valid !== 1'b1 || bus.o_Is_Comma !== 1'b1 || bus.o_10B !== K_POS) begin
      n_fail++;
      $display("FAIL slip_realign: got %b/%b/%b expected 1/1/%b", bus.o_Sym_Valid, bus.o_Is_Comma, bus.o_10B, K_POS);
    end
    send_n(16'(K_NEG), 10, 1'b0);
    lk[1] = bus.o_Locked;
    send_n(16'(K_POS), 10, 1'b0);
    lk[2] = bus.o_Locked;
    n_checks++;
    if (lk !== 3'b100) begin
      n_fail++;
      $display("FAIL slip_lock_sequence: got %b expected 100", lk);
    end
    foreach (obs_q[i]) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL slip_model cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_loss_of_lock();
    do_reset();
    clear_logs();
    lock_up();
    send_n(16'b000, 3, 1'b0);
    for (int i = 0; i < 3; i++) send_n(16'(K_NEG), 10, 1'b0);
    send_n(16'b0, 7, 1'b0);
    send_n(16'(K_NEG), 10, 1'b0);
    send_n(16'b000, 3, 1'b0);
    for (int i = 0; i < 3; i++) send_n(16'(K_NEG), 10, 1'b0);
    n_checks++;
    if (bus.o_Locked !== 1'b1 || bus.o_Loss_Cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL loss_ecnt_reset: got locked=%b loss=%0d expected locked=1 loss=0", bus.o_Locked, bus.o_Loss_Cnt);
    end
    send_n(16'(K_NEG), 10, 1'b0);
    n_checks++;
    if (bus.o_Locked !== 1'b0 || bus.o_Loss_Cnt !== 8'd1 || bus.o_Sym_Valid !== 1'b0) begin
      n_fail++;
      $display("FAIL loss_drop: got locked=%b loss=%0d sv=%b expected locked=0 loss=1 sv=0",
               bus.o_Locked, bus.o_Loss_Cnt, bus.o_Sym_Valid);
    end
    foreach (obs_q[i]) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL loss_model cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_forced_realign();
    logic [1:0] lk;
    do_reset();
    clear_logs();
    lock_up();
    send_n(16'(K_NEG >> 1), 9, 1'b0);
    step(K_NEG[0], 1'b1, 1'b1);
    n_checks++;
    if (bus.o_Sym_Valid !== 1'b0 || bus.o_Locked !== 1'b0 || bus.o_Loss_Cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL realign_effect: got sv=%b locked=%b loss=%0d expected sv=0 locked=0 loss=1",
               bus.o_Sym_Valid, bus.o_Locked, bus.o_Loss_Cnt);
    end
    send_n(16'(K_NEG), 10, 1'b0);
    send_n(16'(K_POS), 10, 1'b0);
    lk[1] = bus.o_Locked;
    send_n(16'(K_NEG), 10, 1'b0);
    lk[0] = bus.o_Locked;
    n_checks++;
    if (lk !== 2'b01) begin
      n_fail++;
      $display("FAIL realign_relock: got %b expected 01", lk);
    end
    foreach (obs_q[i]) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL realign_model cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [9:0] sym;
    int kind;
    do_reset();
    clear_logs();
    for (int s = 0; s < 400; s++) begin
      kind = $urandom_range(0, 20);
      if (kind == 20) begin
        step(1'($urandom), 1'($urandom), 1'b1);
      end else if (kind == 19) begin
        send_n(16'($urandom), $urandom_range(1, 9), 1'b0);
      end else begin
        sym = (kind < 11) ? (kind[0] ? K_POS : K_NEG) : 10'($urandom);
        for (int i = 9; i >= 0; i--) begin
          while ($urandom_range(0, 3) == 0) step(1'($urandom), 1'b0, 1'b0);
          step(sym[i], 1'b1, 1'b0);
        end
      end
    end
    foreach (obs_q[i]) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL random_model cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    bus.i_Ser_Data  = 1'b0;
    bus.i_Bit_Valid = 1'b0;
    bus.i_Realign   = 1'b0;
    #1;
    test_reset();
    test_acquire(1'b0);
    test_acquire(1'b1);
    test_slip();
    test_loss_of_lock();
    test_forced_realign();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
